// File: rtl/tpu_ctrl_pkg.sv
// Items shared by the read-feed and write-back controllers: address width,
// sequencer state encoding and the packed per-lane address slice helper.
package tpu_ctrl_pkg;

  localparam int ADDR_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Lowest bit of lane `lane` inside a packed bus of `aw`-bit lane fields.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned aw);
    return lane * aw;
  endfunction

endpackage

// File: rtl/pulse_delay.sv
// Fixed-depth shift line: a one-cycle pulse on trigger reappears on pulse
// exactly DEPTH cycles later. Only reset clears pulses in flight.
module pulse_delay #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic pulse
);

  logic [DEPTH-1:0] line;

  // The concatenation drops the oldest bit, which also covers DEPTH == 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) line <= '0;
    else        line <= DEPTH'({line, trigger});
  end

  assign pulse = line[DEPTH-1];

endmodule

// File: rtl/rd_feed_control.sv
// Read-side sequencer for the systolic array: skewed per-lane read enables and
// addresses after a start, plus a delayed wr_active pulse for the write side.
module rd_feed_control
  import tpu_ctrl_pkg::*;
#(
  parameter int width_height = 16,
  parameter int addr_width   = ADDR_W,
  parameter int sys_latency  = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [7:0]                         num_rows,
  input  logic [addr_width-1:0]              base_addr,
  output logic [width_height-1:0]            rd_en,
  output logic [addr_width*width_height-1:0] rd_addr,
  output logic                               busy,
  output logic                               done,
  output logic                               wr_active
);

  localparam int CNT_W = $clog2(255 + width_height);

  logic [1:0]                         state, state_nxt;
  logic [CNT_W-1:0]                   cnt, cnt_nxt, last_cnt, off;
  logic [7:0]                         rows_q, rows_nxt;
  logic [addr_width-1:0]              base_q, base_nxt;
  logic [width_height-1:0]            en_nxt;
  logic [addr_width*width_height-1:0] addr_nxt;
  logic                               marker;

  assign last_cnt = CNT_W'(rows_q) + CNT_W'(width_height) - CNT_W'(2);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rows_nxt  = rows_q;
    base_nxt  = base_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          rows_nxt  = num_rows;
          base_nxt  = base_addr;
          cnt_nxt   = '0;
          state_nxt = (num_rows != 8'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (cnt == last_cnt)  state_nxt = ST_DONE;
        else if (cnt != '1)   cnt_nxt   = cnt + CNT_W'(1);
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so lane 0 fires in the
  // first cycle after the accepting edge.
  always_comb begin
    en_nxt   = '0;
    addr_nxt = '0;
    off      = '0;
    for (int i = 0; i < width_height; i++) begin
      en_nxt[i] = (state_nxt == ST_RUN) && (cnt_nxt >= CNT_W'(i)) &&
                  (cnt_nxt < CNT_W'(i) + CNT_W'(rows_nxt));
      off = cnt_nxt - CNT_W'(i);
      addr_nxt[lane_lsb(i, addr_width) +: addr_width] =
        en_nxt[i] ? base_nxt + addr_width'(off) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rows_q  <= '0;
      base_q  <= '0;
      rd_en   <= '0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rows_q  <= rows_nxt;
      base_q  <= base_nxt;
      rd_en   <= en_nxt;
      rd_addr <= addr_nxt;
      busy    <= (state_nxt != ST_IDLE);
      done    <= (state_nxt == ST_DONE);
    end
  end

  // The first RUN cycle is the only one with cnt == 0 while running.
  assign marker = (state == ST_RUN) && (cnt == '0);

  pulse_delay #(.DEPTH(sys_latency)) u_wr_delay (
    .clk     (clk),
    .reset   (reset),
    .trigger (marker),
    .pulse   (wr_active)
  );

endmodule

// File: tb/tb_rd_feed_control.sv
// Directed bench for rd_feed_control with hand-computed expectations.
module tb_rd_feed_control;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   num_rows;
  logic [7:0]   base_addr;
  logic [15:0]  rd_en;
  logic [127:0] rd_addr;
  logic         busy;
  logic         done;
  logic         wr_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic saw_wr;

  rd_feed_control #(.width_height(16), .addr_width(8), .sys_latency(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_rows  (num_rows),
    .base_addr (base_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .wr_active (wr_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int i);
    return rd_addr[8*i +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Start is driven in cycle 0; returns in cycle 1 after the accepting edge.
  task automatic start_run(input logic [7:0] rows, input logic [7:0] base);
    num_rows  = rows;
    base_addr = base;
    start     = 1'b1;
    cyc       = 0;
    tick();
    start     = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {rd_en, rd_addr, busy, done, wr_active}, '0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_rows = 8'd0; base_addr = 8'd0;

    // 1: reset held with start toggling, then idle after release
    for (int i = 0; i < 4; i++) begin
      start = ~start; num_rows = 8'd5;
      tick();
    end
    chk_idle("reset_hold");
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("idle_after_reset");
    end

    // 2: num_rows=3, base 0x10
    start_run(8'd3, 8'h10);
    chk("t2_c1_en", rd_en, 16'h0001);
    chk("t2_c1_l0", lane(0), 8'h10);
    chk("t2_c1_busy", busy, 1'b1);
    run_to(2);
    chk("t2_c2_en", rd_en, 16'h0003);
    chk("t2_c2_l0", lane(0), 8'h11);
    chk("t2_c2_l1", lane(1), 8'h10);
    run_to(3);
    chk("t2_c3_en", rd_en, 16'h0007);
    chk("t2_c3_l2", lane(2), 8'h10);
    run_to(4);
    chk("t2_c4_en", rd_en, 16'h000E);
    chk("t2_c4_l0", lane(0), 8'h00);
    run_to(18);
    chk("t2_c18_en", rd_en, 16'h8000);
    chk("t2_c18_l15", lane(15), 8'h12);
    chk("t2_c18_done", done, 1'b0);
    run_to(19);
    chk("t2_c19_done_busy", {done, busy}, 2'b11);
    chk("t2_c19_en", rd_en, 16'h0000);
    chk("t2_c19_addr", rd_addr, '0);
    run_to(20);
    chk("t2_c20_done_busy", {done, busy}, 2'b00);
    run_to(32);
    chk("t2_c32_wr", wr_active, 1'b0);
    run_to(33);
    chk("t2_c33_wr", wr_active, 1'b1);
    run_to(34);
    chk("t2_c34_wr", wr_active, 1'b0);

    // 3: num_rows=16, base 0
    start_run(8'd16, 8'h00);
    run_to(15);
    chk("t3_c15_en", rd_en, 16'h7FFF);
    run_to(16);
    chk("t3_c16_en", rd_en, 16'hFFFF);
    chk("t3_c16_l15", lane(15), 8'h00);
    chk("t3_c16_l0", lane(0), 8'h0F);
    run_to(17);
    chk("t3_c17_en", rd_en, 16'hFFFE);
    chk("t3_c17_l15", lane(15), 8'h01);
    chk("t3_c17_l0", lane(0), 8'h00);
    run_to(31);
    chk("t3_c31_en", rd_en, 16'h8000);
    chk("t3_c31_done", done, 1'b0);
    run_to(32);
    chk("t3_c32_done", done, 1'b1);
    run_to(33);
    chk("t3_c33_wr", wr_active, 1'b1);
    chk("t3_c33_busy", busy, 1'b0);
    run_to(34);

    // 4: address wrap and wr_active timing
    start_run(8'd4, 8'hFE);
    chk("t4_c1_l0", lane(0), 8'hFE);
    run_to(2);
    chk("t4_c2_l0", lane(0), 8'hFF);
    run_to(3);
    chk("t4_c3_l0", lane(0), 8'h00);
    run_to(4);
    chk("t4_c4_l0", lane(0), 8'h01);
    chk("t4_c4_l3", lane(3), 8'hFE);
    run_to(32);
    chk("t4_c32_wr", wr_active, 1'b0);
    run_to(33);
    chk("t4_c33_wr", wr_active, 1'b1);
    run_to(34);
    chk("t4_c34_wr", wr_active, 1'b0);

    // 5a: restart mid-run and at done are both ignored
    start_run(8'd8, 8'h20);
    run_to(5);
    num_rows = 8'd2; base_addr = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_c6_en", rd_en, 16'h003F);
    chk("t5_c6_l0", lane(0), 8'h25);
    run_to(23);
    chk("t5_c23_en", rd_en, 16'h8000);
    chk("t5_c23_l15", lane(15), 8'h27);
    run_to(24);
    chk("t5_c24_done", done, 1'b1);
    num_rows = 8'd3; base_addr = 8'h40; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_c25_after_done", {rd_en, busy, done}, '0);
    run_to(33);
    chk("t5_c33_wr", wr_active, 1'b1);
    run_to(34);

    // 5b: num_rows = 0
    start_run(8'd0, 8'h33);
    chk("t5z_c1_done_busy", {done, busy}, 2'b11);
    chk("t5z_c1_en", rd_en, 16'h0000);
    run_to(2);
    chk("t5z_c2_idle", {rd_en, rd_addr, busy, done}, '0);
    saw_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_active) saw_wr = 1'b1;
    end
    chk("t5z_no_wr", saw_wr, 1'b0);

    // 6: asynchronous reset mid-run
    start_run(8'd8, 8'h00);
    run_to(10);
    chk("t6_c10_en", rd_en, 16'h03FC);
    chk("t6_c10_l2", lane(2), 8'h07);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_clear", {rd_en, rd_addr, busy, done, wr_active}, '0);
    tick();
    reset = 1'b1;
    saw_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_active || busy) saw_wr = 1'b1;
    end
    chk("t6_no_wr_after_abort", saw_wr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
